// File: rtl/sincronizador_filtro.sv
// rtl/sincronizador_filtro.sv - multi-bit synchroniser with per-bit glitch filter and edge pulses
// Optional edge pulse outputs: SINCRONIZADOR_EDGE_EN

module sincronizador_filtro #(
  parameter int   WIDTH  = 4,
  parameter int   STAGES = 2,
  parameter int   FILTER = 3,
  parameter logic INIT   = 1'b0
) (
  input  logic             clkRx,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataAsync,
  output logic [WIDTH-1:0] dataSync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT}};
  localparam logic [3:0]       CNT_LAST = 4'(FILTER - 1);

  // Synchroniser chain: stage 0 samples the pad, last stage is the raw synchronised bit.
  logic [STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0]             sr;

  // Filter state: one 4-bit run-length counter per channel plus the filtered output.
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      data_sync_q, data_sync_d;

  assign sr       = chain_q[STAGES-1];
  assign dataSync = data_sync_q;

  // Plain shift through the chain, no logic between stages.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], dataAsync};
  end

  // Chain registers, every stage cleared to the INIT value on reset.
  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{INIT_VEC}};
    end else begin
      chain_q <= chain_d;
    end
  end

  // Per-bit filter: count consecutive samples that differ from the output; a sample
  // matching the output discards the run, and reaching FILTER samples commits it.
  always_comb begin
    cnt_d       = cnt_q;
    data_sync_d = data_sync_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sr[i] == data_sync_q[i]) begin
        cnt_d[i] = 4'd0;
      end else if (cnt_q[i] == CNT_LAST) begin
        data_sync_d[i] = sr[i];
        cnt_d[i]       = 4'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Filter registers; reset abandons any count in progress.
  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      data_sync_q <= INIT_VEC;
    end else begin
      cnt_q       <= cnt_d;
      data_sync_q <= data_sync_d;
    end
  end

`ifdef SINCRONIZADOR_EDGE_EN
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Edge pulses are registered on the same edge as the output update, so they
  // line up with the new dataSync value and last one cycle by construction.
  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (sr[i] != data_sync_q[i]) && (cnt_q[i] == CNT_LAST);
    end
    rise_d = update & sr;
    fall_d = update & ~sr;
  end

  // Edge pulse registers.
  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: doc/sincronizador_filtro.md
Name: sincronizador_filtro

Overview:
- Parametrised multi-bit successor to the single-bit 2-FF synchroniser.
- Brings WIDTH independent asynchronous bits from the transmitter into the clkRx domain through a configurable-depth flop chain.
- Adds a per-bit stability (glitch) filter after the chain, and optional rise/fall pulse outputs.
- Sits at the receiver input, ahead of the deserialiser and control logic.

Parameters:
- WIDTH, 4, number of independent channels (1..32).
- STAGES, 2, synchroniser flops per channel (2..4).
- FILTER, 3, consecutive identical synchronised samples required before the output changes (1..15). FILTER=1 means no filtering.
- INIT, 0, reset value (all bits) of the chain, filter state and dataSync.

Ports:
- clkRx  input  1  receiver clock; all flops on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dataAsync  input  WIDTH  asynchronous inputs from the transmitter; no timing relation to clkRx.
- dataSync  output  WIDTH  filtered, synchronised data (registered).
- rise  output  WIDTH  one-cycle pulse when dataSync[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when dataSync[i] goes 1->0.

Behaviour:
- Reset:
  - rst asserted clears state immediately, without waiting for a clock edge.
  - Chain flops and dataSync are set to {WIDTH{INIT}}; all counters to 0; rise and fall to 0.
  - Reset applies to every flop and overrides any count in progress.
  - After rst deasserts, a new value needs the full chain delay plus FILTER samples to reach dataSync.
- Chain (per bit i):
  - s1[i] <= dataAsync[i]; s(n)[i] <= s(n-1)[i].
  - The last stage is the raw synchronised bit sr[i].
  - No logic between chain flops.
- Filter (per bit i; counter width 4 bits, unsigned):
  - If sr[i] == dataSync[i]: cnt[i] <= 0.
  - Else if cnt[i] == FILTER-1: dataSync[i] <= sr[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - An sr[i] that returns to the dataSync[i] value before the count completes resets cnt[i] to 0. The glitch is discarded and no output changes.
  - cnt[i] never exceeds FILTER-1, so it never wraps.
- Latency:
  - dataAsync[i] stable before clock edge k and held is first captured at edge k.
  - dataSync[i] changes at edge k+STAGES+FILTER-1.
  - Defaults: edge k+4.
- Glitch rejection: a pulse at sr[i] shorter than FILTER clkRx cycles never reaches dataSync[i].
- Independence:
  - Channels share only clkRx and rst.
  - Simultaneous transitions on several bits are filtered independently.
  - No bus coherency is guaranteed. Multi-bit values must be Gray-coded or handshaked by the user.
- Edge pulses (when enabled):
  - rise[i] is registered at the same edge as a 0->1 update of dataSync[i]; fall[i] likewise for 1->0.
  - Each pulse lasts exactly one cycle.
  - rise[i] and fall[i] are never high together.

Optional Feature:
- Macro: SINCRONIZADOR_EDGE_EN.
- Defined: rise and fall behave as above.
- Undefined:
  - rise and fall are tied to {WIDTH{1'b0}}.
  - No edge flops are synthesised.
  - The port list is unchanged, and dataSync behaviour is identical.

Test Plan (WIDTH=4, STAGES=2, FILTER=3, INIT=0, SINCRONIZADOR_EDGE_EN defined unless stated):
- Reset: rst=1 asynchronously, between clock edges, with dataAsync=4'hF -> dataSync=4'h0, rise=fall=4'h0 immediately; held while rst=1.
- Step: dataAsync 4'h0->4'h1 before edge k, held -> dataSync=4'h1 at edge k+4 (not k+3); rise=4'h1 for exactly one cycle; fall=0.
- Glitch: dataAsync[1] high for exactly 2 cycles -> dataSync stays 4'h0, rise=4'h0 throughout. Repeat with 3 cycles -> dataSync[1] goes to 1, then back to 0 three cycles after the falling input reaches sr, with one rise and one fall pulse.
- Simultaneous: dataAsync 4'h0->4'hA, then 4'hA->4'h5 after dataSync=4'hA -> dataSync passes 4'hA then 4'h5 with no intermediate value; at that update edge rise=4'h5 and fall=4'hA.
- Reset mid-operation: dataAsync[2] rises; assert rst at edge k+3 (count in progress), release later with input still 1 -> dataSync[2] stays 0 during reset, then rises STAGES+FILTER-1=4 edges after the first post-release capture.
- Macro off: repeat the step test without SINCRONIZADOR_EDGE_EN -> dataSync timing identical; rise=fall=4'h0 always.
